// File: rtl/feedback_stream_pkg.sv
// Shared types for the run-length monitor that compresses the feedback NAND arrow output stream.
package feedback_stream_pkg;

   localparam int DEFAULT_LEN_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } run_state_e;

   typedef struct packed {
      logic                     value;
      logic [DEFAULT_LEN_W-1:0] length;
   } run_record_t;

endpackage

// File: rtl/run_fifo.sv
// Small synchronous FIFO with a registered head entry; pointers carry an extra wrap bit.
module run_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      wr_ptr_next;
   logic [AW:0]      rd_ptr_next;
   logic [WIDTH-1:0] head_reg;
   logic [WIDTH-1:0] head_next;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop_ok  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok = push & (~full | pop_ok);
   assign head    = head_reg;

   assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
   assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};

   // The next head is either the entry being written this edge or one already stored.
   always_comb begin
      head_next = head_reg;
      if (rd_ptr_next != wr_ptr_next) begin
         if (rd_ptr_next == wr_ptr_reg)
            head_next = push_data;
         else
            head_next = mem[rd_ptr_next[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         head_reg   <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         head_reg   <= head_next;
      end
   end

endmodule

// File: rtl/run_length_monitor.sv
// Compresses a 1-bit stream into (value, length) run records and offers them on a valid/ready port.
module run_length_monitor
   import feedback_stream_pkg::*;
#(
   parameter int LEN_W = DEFAULT_LEN_W,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             input1,
   input  logic             flush,
   output logic             run_value,
   output logic [LEN_W-1:0] run_length,
   output logic             run_valid,
   input  logic             run_ready,
   output logic             overflow
);

   localparam logic [LEN_W-1:0] MAX_LEN = '1;

   run_state_e       state_reg;
   logic             cur_value_reg;
   logic [LEN_W-1:0] cur_len_reg;
   logic             overflow_reg;
   logic             close_run;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LEN_W:0]   fifo_head;

   // Saturation closes the run so the counter never wraps to a zero-length record.
   assign close_run = flush | (input1 != cur_value_reg) | (cur_len_reg == MAX_LEN);
   assign push      = (state_reg == RUN) & close_run;
   assign run_valid = ~fifo_empty;
   assign pop       = run_valid & run_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cur_value_reg <= 1'b0;
         cur_len_reg   <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg     <= RUN;
               cur_value_reg <= input1;
               cur_len_reg   <= {{(LEN_W-1){1'b0}}, 1'b1};
            end
            RUN: begin
               if (close_run) begin
                  cur_value_reg <= input1;
                  cur_len_reg   <= {{(LEN_W-1){1'b0}}, 1'b1};
               end else begin
                  cur_len_reg   <= cur_len_reg + {{(LEN_W-1){1'b0}}, 1'b1};
               end
            end
            default: state_reg <= IDLE;
         endcase
         if (push & fifo_full & ~pop)
            overflow_reg <= 1'b1;
      end
   end

   run_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (LEN_W + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({cur_value_reg, cur_len_reg}),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign run_value  = fifo_head[LEN_W];
   assign run_length = fifo_head[LEN_W-1:0];
   assign overflow   = overflow_reg;

endmodule
